// File: rtl/cpu_ctrl_pkg.sv
// Purpose : shared encodings for the hardwired CPU control sequencer.
// Latency : n/a (constants and types only).
// Backpressure: n/a. Contents: opcodes, bus/load bit indices, state and class enums.
package cpu_ctrl_pkg;

    // Opcodes that the class decoder singles out; every other value is an ALU-class op.
    localparam logic [4:0] OP_IN   = 5'b01110;
    localparam logic [4:0] OP_OUT  = 5'b01111;
    localparam logic [4:0] OP_LDI  = 5'b10100;
    localparam logic [4:0] OP_LD   = 5'b10101;
    localparam logic [4:0] OP_ST   = 5'b10110;
    localparam logic [4:0] OP_MFLO = 5'b10111;
    localparam logic [4:0] OP_BRZR = 5'b11000;
    localparam logic [4:0] OP_JR   = 5'b11101;
    localparam logic [4:0] OP_MFHI = 5'b11110;
    localparam logic [4:0] OP_HALT = 5'b11111;

    // out_sel bit positions (bus sources); 0..15 are R0..R15.
    localparam int OS_HI  = 16;
    localparam int OS_LO  = 17;
    localparam int OS_ZHI = 18;
    localparam int OS_ZLO = 19;
    localparam int OS_PC  = 20;
    localparam int OS_MDR = 21;
    localparam int OS_IN  = 22;
    localparam int OS_C   = 23;

    // in_sel bit positions (register load enables); 0..15 are R0..R15.
    localparam int IS_HI  = 16;
    localparam int IS_LO  = 17;
    localparam int IS_ZHI = 18;
    localparam int IS_ZLO = 19;
    localparam int IS_PC  = 20;
    localparam int IS_MDR = 21;
    localparam int IS_MAR = 22;
    localparam int IS_IN  = 23;
    localparam int IS_OUT = 24;
    localparam int IS_IR  = 25;

    typedef enum logic [3:0] {
        ST_RST, ST_F0, ST_F1, ST_F2, ST_DEC,
        ST_E0, ST_E1, ST_E2, ST_E3, ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU, CLS_LD, CLS_ST, CLS_OUT, CLS_BR, CLS_HALT
    } op_class_t;

endpackage

// File: rtl/opcode_class_decoder.sv
// Purpose : maps a 5-bit opcode onto the execution class that picks the E-state sequence.
// Latency : combinational.
// Backpressure: none. Ports: opcode in, op_class out. All 32 codes map to a class.
module opcode_class_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_t  op_class
);

    always_comb begin
        op_class = CLS_ALU;
        if (opcode == OP_OUT) begin
            op_class = CLS_OUT;
        end else if (opcode == OP_LDI || opcode == OP_LD) begin
            op_class = CLS_LD;
        end else if (opcode == OP_ST) begin
            op_class = CLS_ST;
        end else if (opcode == OP_HALT) begin
            op_class = CLS_HALT;
        end else if (opcode >= OP_BRZR && opcode <= OP_JR) begin
            // brzr/brnz/brpl/brmi/jal/jr all just load PC
            op_class = CLS_BR;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Purpose : hardwired fetch/decode/execute sequencer driving datapath bus selects and load enables.
// Latency : instruction F0-to-F0 = 7 (ALU/st/branch), 10 (ld) cycles at MEM_WAIT=1; halt reaches HALT in 5.
// Backpressure: stop is sampled only on retirement; HALT parks strobes until stop drops (or clr for halt op).
// Ports: clk, clr (async active-low), stop, ir_in -> out_sel, in_sel, incPC, MDRRead, ALUen, BAOut,
//        AddressCounterEnable, running, instr_count.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int MEM_WAIT = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             stop,
    input  logic [31:0]      ir_in,
    output logic [23:0]      out_sel,
    output logic [25:0]      in_sel,
    output logic             incPC,
    output logic             MDRRead,
    output logic             ALUen,
    output logic             BAOut,
    output logic             AddressCounterEnable,
    output logic             running,
    output logic [CNT_W-1:0] instr_count
);

    // F1 and ld-E1 last 1+MEM_WAIT cycles; st-E1 holds MEM_WAIT cycles (never fewer than one).
    localparam logic [1:0] WAIT_LAST = 2'(MEM_WAIT);
    localparam logic [1:0] ST_LAST   = (MEM_WAIT == 0) ? 2'd0 : 2'(MEM_WAIT - 1);

    state_t     state, state_nxt;
    logic [31:0] ir_q;
    logic [1:0] wcnt;
    logic       last_halt;
    logic       retire;
    logic [4:0] opcode_src;
    op_class_t  cls;
    logic [3:0] rd;
    logic       rb_zero;
    logic       unused_ir_bits;

    // In DEC the IR value is not latched yet, so the class comes straight from ir_in for the
    // branch decision; outputs only ever look at ir_q.
    assign opcode_src = (state == ST_DEC) ? ir_in[31:27] : ir_q[31:27];
    assign rd         = ir_q[26:23];
    assign rb_zero    = (ir_q[18:15] == 4'd0);
    assign unused_ir_bits = ^{ir_q[22:19], ir_q[14:0]};

    opcode_class_decoder u_dec (
        .opcode   (opcode_src),
        .op_class (cls)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state       <= ST_RST;
            ir_q        <= '0;
            wcnt        <= '0;
            last_halt   <= 1'b0;
            instr_count <= '0;
        end else begin
            state <= state_nxt;
            // wcnt counts cycles spent in the current state
            wcnt  <= (state_nxt == state) ? wcnt + 2'd1 : 2'd0;
            if (state == ST_DEC) begin
                ir_q <= ir_in;
            end
            if (retire) begin
                instr_count <= instr_count + CNT_W'(1);
                last_halt   <= (cls == CLS_HALT);
            end
        end
    end

    // Next state and retirement
    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        case (state)
            ST_RST:  state_nxt = ST_F0;
            ST_F0:   state_nxt = ST_F1;
            ST_F1:   if (wcnt == WAIT_LAST) state_nxt = ST_F2;
            ST_F2:   state_nxt = ST_DEC;
            ST_DEC: begin
                if (cls == CLS_HALT) retire = 1'b1;
                else                 state_nxt = ST_E0;
            end
            ST_E0:   state_nxt = ST_E1;
            ST_E1: begin
                case (cls)
                    CLS_LD:  if (wcnt == WAIT_LAST) state_nxt = ST_E2;
                    CLS_ST:  if (wcnt == ST_LAST) retire = 1'b1;
                    default: retire = 1'b1;
                endcase
            end
            ST_E2:   state_nxt = ST_E3;
            ST_E3:   retire = 1'b1;
            ST_HALT: if (!stop && !last_halt) state_nxt = ST_F0;
            default: state_nxt = ST_RST;
        endcase
        if (retire) begin
            state_nxt = (cls == CLS_HALT || stop) ? ST_HALT : ST_F0;
        end
    end

    // Moore outputs
    always_comb begin
        out_sel              = '0;
        in_sel               = '0;
        incPC                = 1'b0;
        MDRRead              = 1'b0;
        ALUen                = 1'b0;
        BAOut                = 1'b0;
        AddressCounterEnable = 1'b0;
        case (state)
            ST_F0: begin
                AddressCounterEnable = 1'b1;
                in_sel[IS_MAR]       = 1'b1;
            end
            // MDR keeps capturing through the settle window so its final value is the settled one
            ST_F1: begin
                MDRRead        = 1'b1;
                in_sel[IS_MDR] = 1'b1;
            end
            ST_F2: begin
                out_sel[OS_MDR] = 1'b1;
                in_sel[IS_IR]   = 1'b1;
                incPC           = 1'b1;
            end
            ST_E0: begin
                case (cls)
                    CLS_ALU, CLS_OUT: ALUen = 1'b1;
                    CLS_LD: begin
                        in_sel[IS_MAR] = 1'b1;
                        BAOut          = rb_zero;
                    end
                    CLS_ST:  in_sel[IS_MAR] = 1'b1;
                    CLS_BR:  in_sel[IS_PC]  = 1'b1;
                    default: ;
                endcase
            end
            ST_E1: begin
                case (cls)
                    CLS_ALU: begin
                        out_sel[OS_C] = 1'b1;
                        in_sel[rd]    = 1'b1;
                    end
                    CLS_OUT: in_sel[IS_OUT] = 1'b1;
                    default: ;
                endcase
            end
            ST_E2: ALUen = 1'b1;
            ST_E3: begin
                out_sel[OS_C] = 1'b1;
                in_sel[rd]    = 1'b1;
            end
            default: ;
        endcase
    end

    assign running = (state != ST_HALT) && (state != ST_RST);

endmodule

// File: tb/tb_control_sequencer.sv
// Purpose : directed table-driven check of control_sequencer plus hand-written reset/wrap sequences.
// Latency : n/a.
// Backpressure: n/a.
module tb_control_sequencer;

    localparam logic [31:0] IR_ALU  = 32'h19890000; // op 00011, rD=3
    localparam logic [31:0] IR_LD   = 32'hAA800000; // op 10101, rD=5, rB=0
    localparam logic [31:0] IR_ST   = 32'hB0000000;
    localparam logic [31:0] IR_BR   = 32'hC0000000;
    localparam logic [31:0] IR_OUT  = 32'h78000000;
    localparam logic [31:0] IR_HALT = 32'hF8000000;

    // strobe order: {incPC, MDRRead, ALUen, BAOut, AddressCounterEnable}
    localparam logic [4:0] S_NONE = 5'b00000;
    localparam logic [4:0] S_INC  = 5'b10000;
    localparam logic [4:0] S_MDR  = 5'b01000;
    localparam logic [4:0] S_ALU  = 5'b00100;
    localparam logic [4:0] S_BA   = 5'b00010;
    localparam logic [4:0] S_ACE  = 5'b00001;

    typedef struct {
        logic        clr;
        logic        stop;
        logic [31:0] ir;
        logic [23:0] osel;
        logic [25:0] isel;
        logic [4:0]  strb;
        logic        run;
        logic [15:0] cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        clr, stop;
    logic [31:0] ir_in;
    logic [23:0] out_sel;
    logic [25:0] in_sel;
    logic        incPC, MDRRead, ALUen, BAOut, AddressCounterEnable, running;
    logic [15:0] instr_count;

    logic        clr2;
    logic        stop2 = 1'b0;
    logic [31:0] ir2 = IR_ALU;
    logic [23:0] out_sel2;
    logic [25:0] in_sel2;
    logic        incPC2, MDRRead2, ALUen2, BAOut2, ace2, running2;
    logic [2:0]  instr_count2;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    wire [4:0] strb = {incPC, MDRRead, ALUen, BAOut, AddressCounterEnable};

    always #5 clk = ~clk;

    control_sequencer #(.CNT_W(16), .MEM_WAIT(1)) u_dut (
        .clk(clk), .clr(clr), .stop(stop), .ir_in(ir_in),
        .out_sel(out_sel), .in_sel(in_sel), .incPC(incPC), .MDRRead(MDRRead),
        .ALUen(ALUen), .BAOut(BAOut), .AddressCounterEnable(AddressCounterEnable),
        .running(running), .instr_count(instr_count)
    );

    control_sequencer #(.CNT_W(3), .MEM_WAIT(0)) u_dut_wrap (
        .clk(clk), .clr(clr2), .stop(stop2), .ir_in(ir2),
        .out_sel(out_sel2), .in_sel(in_sel2), .incPC(incPC2), .MDRRead(MDRRead2),
        .ALUen(ALUen2), .BAOut(BAOut2), .AddressCounterEnable(ace2),
        .running(running2), .instr_count(instr_count2)
    );

    function automatic logic [23:0] oh24(input int b);
        return 24'(1) << b;
    endfunction

    function automatic logic [25:0] oh26(input int b);
        return 26'(1) << b;
    endfunction

    task automatic row(input logic c, input logic s, input logic [31:0] ir, input logic [23:0] o,
                       input logic [25:0] i, input logic [4:0] st, input logic r, input logic [15:0] n);
        vec_t v;
        v.clr = c; v.stop = s; v.ir = ir; v.osel = o; v.isel = i; v.strb = st; v.run = r; v.cnt = n;
        tbl.push_back(v);
    endtask

    // F1, F1 settle, F2, DEC
    task automatic fetch(input logic [31:0] ir, input logic [15:0] n);
        row(1, 0, ir, 24'h0, oh26(21), S_MDR, 1, n);
        row(1, 0, ir, 24'h0, oh26(21), S_MDR, 1, n);
        row(1, 0, ir, oh24(21), oh26(25), S_INC, 1, n);
        row(1, 0, ir, 24'h0, 26'h0, S_NONE, 1, n);
    endtask

    task automatic check(input string name, input logic [23:0] o, input logic [25:0] i,
                         input logic [4:0] st, input logic r, input logic [15:0] n);
        checks++;
        if (out_sel !== o || in_sel !== i || strb !== st || running !== r || instr_count !== n) begin
            errors++;
            $display("FAIL %s: got osel=%h isel=%h strb=%b run=%b cnt=%h, want osel=%h isel=%h strb=%b run=%b cnt=%h",
                     name, out_sel, in_sel, strb, running, instr_count, o, i, st, r, n);
        end
    endtask

    // Structural invariants on every active cycle
    always @(negedge clk) begin
        if (clr) begin
            checks++;
            if (!$onehot0(out_sel) || !$onehot0(in_sel[15:0]) || (incPC && in_sel[20])) begin
                errors++;
                $display("FAIL invariant: osel=%h isel=%h incPC=%b", out_sel, in_sel, incPC);
            end
        end
    end

    initial begin
        int lat;
        logic [2:0] prev;

        clr = 1'b0; stop = 1'b0; ir_in = '0; clr2 = 1'b0;

        // ALU (rD=3)
        row(1, 0, IR_ALU, 24'h0, oh26(22), S_ACE, 1, 0);
        fetch(IR_ALU, 0);
        row(1, 0, IR_ALU, 24'h0, 26'h0, S_ALU, 1, 0);
        row(1, 0, IR_ALU, oh24(23), oh26(3), S_NONE, 1, 0);
        row(1, 0, IR_ALU, 24'h0, oh26(22), S_ACE, 1, 1);
        // ld rD=5 rB=0: E0, E1, E1 settle, E2, E3
        fetch(IR_LD, 1);
        row(1, 0, IR_LD, 24'h0, oh26(22), S_BA, 1, 1);
        row(1, 0, IR_LD, 24'h0, 26'h0, S_NONE, 1, 1);
        row(1, 0, IR_LD, 24'h0, 26'h0, S_NONE, 1, 1);
        row(1, 0, IR_LD, 24'h0, 26'h0, S_ALU, 1, 1);
        row(1, 0, IR_LD, oh24(23), oh26(5), S_NONE, 1, 1);
        row(1, 0, IR_LD, 24'h0, oh26(22), S_ACE, 1, 2);
        // st
        fetch(IR_ST, 2);
        row(1, 0, IR_ST, 24'h0, oh26(22), S_NONE, 1, 2);
        row(1, 0, IR_ST, 24'h0, 26'h0, S_NONE, 1, 2);
        row(1, 0, IR_ST, 24'h0, oh26(22), S_ACE, 1, 3);
        // brzr
        fetch(IR_BR, 3);
        row(1, 0, IR_BR, 24'h0, oh26(20), S_NONE, 1, 3);
        row(1, 0, IR_BR, 24'h0, 26'h0, S_NONE, 1, 3);
        row(1, 0, IR_BR, 24'h0, oh26(22), S_ACE, 1, 4);
        // out
        fetch(IR_OUT, 4);
        row(1, 0, IR_OUT, 24'h0, 26'h0, S_ALU, 1, 4);
        row(1, 0, IR_OUT, 24'h0, oh26(24), S_NONE, 1, 4);
        row(1, 0, IR_OUT, 24'h0, oh26(22), S_ACE, 1, 5);
        // ALU with stop: ignored on E0->E1, honoured at retirement
        fetch(IR_ALU, 5);
        row(1, 0, IR_ALU, 24'h0, 26'h0, S_ALU, 1, 5);
        row(1, 1, IR_ALU, oh24(23), oh26(3), S_NONE, 1, 5);
        row(1, 1, IR_ALU, 24'h0, 26'h0, S_NONE, 0, 6);
        row(1, 1, IR_ALU, 24'h0, 26'h0, S_NONE, 0, 6);
        row(1, 0, IR_ALU, 24'h0, oh26(22), S_ACE, 1, 6);
        // halt opcode: retires from DEC, stays parked with stop=0
        fetch(IR_HALT, 6);
        row(1, 0, IR_HALT, 24'h0, 26'h0, S_NONE, 0, 7);
        row(1, 0, IR_HALT, 24'h0, 26'h0, S_NONE, 0, 7);
        row(1, 0, IR_HALT, 24'h0, 26'h0, S_NONE, 0, 7);
        row(1, 0, IR_HALT, 24'h0, 26'h0, S_NONE, 0, 7);

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 24'h0, 26'h0, S_NONE, 0, 0);

        for (int k = 0; k < tbl.size(); k++) begin
            clr = tbl[k].clr; stop = tbl[k].stop; ir_in = tbl[k].ir;
            @(posedge clk);
            #1;
            check($sformatf("row%0d", k), tbl[k].osel, tbl[k].isel, tbl[k].strb, tbl[k].run, tbl[k].cnt);
        end

        // clr leaves halt and clears the counter immediately
        clr = 1'b0;
        #1;
        check("clr_from_halt", 24'h0, 26'h0, S_NONE, 0, 0);
        @(posedge clk);
        #1;
        clr = 1'b1; ir_in = IR_ALU;
        #2;
        check("rst_cycle", 24'h0, 26'h0, S_NONE, 0, 0);
        @(posedge clk);
        #1;
        check("rst_to_f0", 24'h0, oh26(22), S_ACE, 1, 0);
        repeat (7) @(posedge clk);
        #1;
        check("alu_after_reset", 24'h0, oh26(22), S_ACE, 1, 1);
        repeat (5) @(posedge clk);
        #1;
        check("mid_e0", 24'h0, 26'h0, S_ALU, 1, 1);
        #2;
        clr = 1'b0;
        #1;
        check("async_clr_mid_e0", 24'h0, 26'h0, S_NONE, 0, 0);

        // Narrow counter, MEM_WAIT=0: 7 edges to first retirement, then 6 each; 8th wraps to 0
        @(posedge clk);
        #1;
        clr2 = 1'b1;
        prev = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            lat = 0;
            do begin
                @(posedge clk);
                #1;
                lat++;
            end while (instr_count2 == prev && lat < 20);
            checks++;
            if (instr_count2 !== 3'(k) || lat != ((k == 1) ? 7 : 6)) begin
                errors++;
                $display("FAIL wrap_retire%0d: got cnt=%0d lat=%0d, want cnt=%0d lat=%0d",
                         k, instr_count2, lat, 3'(k), (k == 1) ? 7 : 6);
            end
            prev = instr_count2;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
